// File: rtl/key_event_pkg.sv
// Shared types, defaults and sizing helpers for the key conditioning front end.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined (see key_channel).
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } key_fsm_e;

  localparam int DEF_DEBOUNCE_MS     = 20;
  localparam int DEF_REPEAT_DELAY_MS = 500;
  localparam int DEF_REPEAT_RATE_MS  = 100;

  function automatic int ms_to_cycles(input int f_clk, input int ms);
    return (f_clk / 1000) * ms;
  endfunction

  function automatic int ms_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  localparam int MS_CNT_W = ms_cnt_width(DEF_DEBOUNCE_MS, DEF_REPEAT_DELAY_MS,
                                         DEF_REPEAT_RATE_MS);

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, tick-sampled debounce, press/release/repeat pulses.
// Macro KEY_AUTOREPEAT_EN selects the IDLE/HOLD_WAIT/REPEAT FSM; otherwise IDLE/HELD.
module key_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_repeat_pulse
);

  localparam int CNT_W = ms_cnt_width(DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS);

  logic             sync1_q, sync2_q;
  logic             samp_q, samp_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             accept;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  key_fsm_e         state_q, state_d;

  // The level is captured on one tick and judged on the next, so a change
  // must survive DEBOUNCE_MS full tick periods before it is accepted.
  always_comb begin
    samp_d    = samp_q;
    deb_cnt_d = deb_cnt_q;
    pressed_d = pressed_q;
    accept    = 1'b0;
    if (i_tick) begin
      samp_d = ~sync2_q;
      if (samp_q == pressed_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q + CNT_W'(1) == DEB_LAST) begin
        deb_cnt_d = '0;
        pressed_d = ~pressed_q;
        accept    = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end else begin
      samp_d = samp_q;
    end
    press_d = accept & ~pressed_q;
    rel_d   = accept & pressed_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      samp_q    <= 1'b0;
      pressed_q <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      sync1_q   <= i_key_n;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      pressed_q <= pressed_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_MS);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_MS);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic             rep_q, rep_d;

  // A release accepted on this tick overrides any repeat due on the same tick.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    rep_d     = 1'b0;
    rep_inc   = rep_cnt_q + CNT_W'(1);
    if (rel_d) begin
      state_d   = IDLE;
      rep_cnt_d = '0;
    end else if (press_d) begin
      state_d   = HOLD_WAIT;
      rep_cnt_d = '0;
    end else if (i_tick) begin
      case (state_q)
        HOLD_WAIT: begin
          if (rep_inc == DELAY_LAST) begin
            state_d   = REPEAT;
            rep_cnt_d = '0;
            rep_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
        REPEAT: begin
          if (rep_inc == RATE_LAST) begin
            rep_cnt_d = '0;
            rep_d     = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
        default: begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end

  assign o_repeat_pulse = rep_q;
`else
  // HOLD_WAIT doubles as the HELD state when auto-repeat is not built.
  always_comb begin
    state_d = state_q;
    if (rel_d) begin
      state_d = IDLE;
    end else if (press_d) begin
      state_d = HOLD_WAIT;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_repeat_pulse = 1'b0;
`endif

  assign o_pressed       = pressed_q;
  assign o_press_pulse   = press_q;
  assign o_release_pulse = rel_q;

endmodule

// File: rtl/key_event_gen.sv
// Key conditioning top: shared 1 ms tick generator plus one key_channel per key.
// Define KEY_AUTOREPEAT_EN to build the auto-repeat logic in every channel.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int F_CLK           = 50000000,
  parameter int NUM_KEYS        = 6,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_KEYS-1:0] i_key,
  output logic [NUM_KEYS-1:0] o_pressed,
  output logic [NUM_KEYS-1:0] o_press_pulse,
  output logic [NUM_KEYS-1:0] o_release_pulse,
  output logic [NUM_KEYS-1:0] o_repeat_pulse,
  output logic                o_tick_1ms
);

  localparam int TICK_CYCLES = ms_to_cycles(F_CLK, 1);
  localparam int TICK_W      = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;

  // The strobe flop mirrors "counter == last" so the tick is a clean register output.
  always_comb begin
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
    tick_d = (tick_cnt_d == TICK_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign o_tick_1ms = tick_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_channel (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_tick         (tick_q),
      .i_key_n        (i_key[g]),
      .o_pressed      (o_pressed[g]),
      .o_press_pulse  (o_press_pulse[g]),
      .o_release_pulse(o_release_pulse[g]),
      .o_repeat_pulse (o_repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Randomised bench for key_event_gen with an in-bench behavioural model
// (tick-window debounce and repeat schedule) plus directed scenario checks.
`timescale 1ns/1ps
module tb_key_event_gen;
  localparam int F_CLK = 10000;
  localparam int NK    = 6;
  localparam int DEB   = 4;
  localparam int DELAY = 20;
  localparam int RATE  = 5;
  localparam int TC    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] o_pressed, o_press, o_rel, o_rep;
  logic          o_tick;

  always #5 clk = ~clk;

  key_event_gen #(
    .F_CLK(F_CLK), .NUM_KEYS(NK), .DEBOUNCE_MS(DEB),
    .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key),
    .o_pressed(o_pressed), .o_press_pulse(o_press), .o_release_pulse(o_rel),
    .o_repeat_pulse(o_rep), .o_tick_1ms(o_tick)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit valid = 1'b0;

  // Model state: raw key seen two edges back, last DEB tick samples per key,
  // edge and tick counts since reset, tick index of each accepted press.
  logic [NK-1:0]  kh1, kh2, lvl, m_pressed, m_press, m_rel, m_rep;
  logic           m_tick;
  logic [DEB-1:0] hist [NK];
  int             nsamp [NK];
  int             press_tk [NK];
  int             ecnt, tk, el;
  bit             tick_now, acc;

  initial forever begin
    @(posedge clk);
    cyc++;
    valid = 1'b1;
    if (rst) begin
      kh1 = '1; kh2 = '1;
      m_pressed = '0; m_press = '0; m_rel = '0; m_rep = '0; m_tick = 1'b0;
      ecnt = 0; tk = 0;
      for (int k = 0; k < NK; k++) begin
        hist[k] = '0; nsamp[k] = 0; press_tk[k] = 0;
      end
    end else begin
      tick_now = ((ecnt % TC) == TC - 1);
      lvl = ~kh2; kh2 = kh1; kh1 = key;
      m_press = '0; m_rel = '0; m_rep = '0;
      if (tick_now) begin
        for (int k = 0; k < NK; k++) begin
          acc = (nsamp[k] >= DEB) && (hist[k] == {DEB{~m_pressed[k]}});
          if (acc) begin
            if (m_pressed[k]) m_rel[k] = 1'b1;
            else begin m_press[k] = 1'b1; press_tk[k] = tk; end
            m_pressed[k] = ~m_pressed[k];
          end else if (m_pressed[k]) begin
`ifdef KEY_AUTOREPEAT_EN
            el = tk - press_tk[k];
            if (el >= DELAY && ((el - DELAY) % RATE) == 0) m_rep[k] = 1'b1;
`endif
          end
          hist[k] = {hist[k][DEB-2:0], lvl[k]};
          if (nsamp[k] < DEB) nsamp[k]++;
        end
        tk++;
      end
      ecnt++;
      m_tick = ((ecnt % TC) == TC - 1);
    end
  end

  task automatic chk(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d..%0d", nm, cyc, act, lo, hi);
    end
  endtask

  // Event log consumed by the directed scenarios.
  int press_cnt [NK], rel_cnt [NK], rep_cnt [NK], last_press_at [NK], last_rel_at [NK];
  int rep_q0 [$];

  task automatic clear_log();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; rep_cnt[k] = 0;
      last_press_at[k] = -1; last_rel_at[k] = -1;
    end
    rep_q0.delete();
  endtask

  initial forever begin
    @(negedge clk);
    if (valid) begin
      chk("tick", {{(NK-1){1'b0}}, o_tick}, {{(NK-1){1'b0}}, m_tick});
      chk("pressed", o_pressed, m_pressed);
      chk("press_pulse", o_press, m_press);
      chk("release_pulse", o_rel, m_rel);
      chk("repeat_pulse", o_rep, m_rep);
      for (int k = 0; k < NK; k++) begin
        if (o_press[k] === 1'b1) begin press_cnt[k]++; last_press_at[k] = cyc; end
        if (o_rel[k] === 1'b1) begin rel_cnt[k]++; last_rel_at[k] = cyc; end
        if (o_rep[k] === 1'b1) begin
          rep_cnt[k]++;
          if (k == 0) rep_q0.push_back(cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int n0, p, e, nexp;
  int nxt [NK];

  initial begin
    clear_log();
    step(3);
    lit("reset_pressed", int'(o_pressed), 0, 0);
    lit("reset_pulses", int'(o_press | o_rel | o_rep), 0, 0);
    lit("reset_tick", int'(o_tick), 0, 0);
    rst = 1'b0;

    // Clean press held 600 cycles, with auto-repeat schedule.
    clear_log(); n0 = cyc; key[0] = 1'b0; step(600);
    lit("clean_press_cnt", press_cnt[0], 1, 1);
    p = last_press_at[0];
    lit("clean_press_lat", p - n0, 42, 52);
    lit("clean_pressed", int'(o_pressed[0]), 1, 1);
`ifdef KEY_AUTOREPEAT_EN
    nexp = (cyc - p - 200) / 50 + 1;
    lit("repeat_cnt", rep_q0.size(), nexp, nexp);
    for (int i = 0; i < rep_q0.size(); i++)
      lit("repeat_time", rep_q0[i] - p, 200 + 50 * i, 200 + 50 * i);
`else
    lit("repeat_none", rep_cnt[0], 0, 0);
`endif

    // Clean release.
    clear_log(); n0 = cyc; key[0] = 1'b1; step(100);
    lit("release_cnt", rel_cnt[0], 1, 1);
    lit("release_lat", last_rel_at[0] - n0, 42, 52);
    lit("released", int'(o_pressed[0]), 0, 0);

    // Glitch shorter than the debounce window.
    clear_log(); key[2] = 1'b0; step(25); key[2] = 1'b1; step(100);
    lit("glitch_press_cnt", press_cnt[2], 0, 0);
    lit("glitch_pressed", int'(o_pressed[2]), 0, 0);

    // Bounce every 15 cycles, settling low.
    clear_log();
    for (int i = 0; i < 7; i++) begin
      key[1] = i[0];
      n0 = cyc;
      if (i < 6) step(15);
    end
    step(150);
    lit("bounce_press_cnt", press_cnt[1], 1, 1);
    lit("bounce_press_lat", last_press_at[1] - n0, 40, 52);
    lit("bounce_release_cnt", rel_cnt[1], 0, 0);
    key[1] = 1'b1; step(100);

    // Reset while held (in REPEAT when auto-repeat is built).
    key[0] = 1'b0; step(350);
    rst = 1'b1; step(1);
    lit("midrst_pressed", int'(o_pressed), 0, 0);
    lit("midrst_pulses", int'(o_press | o_rel | o_rep), 0, 0);
    lit("midrst_tick", int'(o_tick), 0, 0);
    step(2); rst = 1'b0;
    clear_log(); n0 = cyc; step(80);
    lit("post_rst_press_cnt", press_cnt[0], 1, 1);
    lit("post_rst_press_lat", last_press_at[0] - n0, 42, 52);
    key[0] = 1'b1; step(100);

    // Concurrent press on keys 0 and 5.
    clear_log(); key[0] = 1'b0; key[5] = 1'b0; step(70);
    lit("conc_press0", press_cnt[0], 1, 1);
    lit("conc_press5", press_cnt[5], 1, 1);
    lit("conc_same_cycle", last_press_at[0] - last_press_at[5], 0, 0);
`ifdef KEY_AUTOREPEAT_EN
    clear_log();
    for (int i = 0; i < 400 && rep_cnt[0] == 0; i++) step(1);
    lit("repeat_wait", rep_cnt[0], 1, 1);
`endif
    // Released right on a repeat so acceptance lands on the next repeat tick.
    key[0] = 1'b1; key[5] = 1'b1; n0 = cyc;
    clear_log(); step(70);
    lit("clash_release_cnt", rel_cnt[0], 1, 1);
    lit("clash_repeat_cnt", rep_cnt[0], 0, 0);
`ifdef KEY_AUTOREPEAT_EN
    lit("clash_release_lat", last_rel_at[0] - n0, 50, 50);
`endif

    // Randomised phase: mixed bounces and long holds, one reset in the middle.
    for (int k = 0; k < NK; k++) nxt[k] = cyc + int'($urandom_range(1, 50));
    for (int c = 0; c < 16000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (cyc >= nxt[k]) begin
          key[k] = ~key[k];
          if ($urandom_range(0, 1) == 0) nxt[k] = cyc + int'($urandom_range(1, 30));
          else nxt[k] = cyc + int'($urandom_range(31, 700));
        end
      end
      if (c == 8000) rst = 1'b1;
      if (c == 8002) rst = 1'b0;
      step(1);
    end
    key = '1; step(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
